// File: rtl/mm_tag_issuer_if.sv
// Job request handshake for the modular-multiplication tag issuer.
// The requester drives the job fields and holds them until it sees ready.
interface mm_tag_issuer_if #(
    parameter int unsigned INFO_W = 8
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_type;
    logic [INFO_W-1:0] req_info;
    logic              req_last;

    modport master (
        output req_valid,
        output req_type,
        output req_info,
        output req_last,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_type,
        input  req_info,
        input  req_last,
        output req_ready
    );
endinterface

// File: rtl/mm_tag_issuer.sv
// Issue side of the 4-entry stage/mm_info tag buffer: issues en_a/en_c strobes with tags,
// spaces issues per job type and holds a credit count refilled by retire strobes.
module mm_tag_issuer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned INFO_W = 8,
    parameter int unsigned GAP_A  = 4,
    parameter int unsigned GAP_C  = 3
) (
    input  logic              clk,
    input  logic              rst,
    mm_tag_issuer_if.slave    req,
    output logic              en_a,
    output logic              en_c,
    output logic [1:0]        stage_num_out,
    output logic [INFO_W-1:0] mm_info_out,
    input  logic              en_out_a,
    input  logic              en_out_c,
    output logic [2:0]        credits,
    output logic              stage_wrap,
    output logic              err_retire
);

    localparam logic [2:0] DepthC = 3'(DEPTH);
    localparam logic [2:0] GapALd = 3'(GAP_A - 1);
    localparam logic [2:0] GapCLd = 3'(GAP_C - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StGap
    } state_e;

    state_e     state_q;
    logic [2:0] gap_cnt_q;
    logic [1:0] stage_q;
    logic       last_q;

    logic accept;
    logic issue;
    logic retire;

    assign req.req_ready = (state_q == StIdle) && (credits != 3'd0);
    assign accept        = req.req_valid && req.req_ready;
    assign issue         = (state_q == StIssue);
    assign retire        = en_out_a || en_out_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            gap_cnt_q     <= 3'd0;
            stage_q       <= 2'd0;
            last_q        <= 1'b0;
            en_a          <= 1'b0;
            en_c          <= 1'b0;
            stage_num_out <= 2'd0;
            mm_info_out   <= '0;
            stage_wrap    <= 1'b0;
            credits       <= DepthC;
            err_retire    <= 1'b0;
        end else begin
            en_a       <= 1'b0;
            en_c       <= 1'b0;
            stage_wrap <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q       <= StIssue;
                        en_a          <= !req.req_type;
                        en_c          <= req.req_type;
                        stage_num_out <= stage_q;
                        mm_info_out   <= req.req_info;
                        last_q        <= req.req_last;
                        // Counter holds GAP-1 during the issue cycle; IDLE is reached
                        // when it hits 0, giving GAP cycles between strobes.
                        gap_cnt_q     <= req.req_type ? GapCLd : GapALd;
                    end
                end
                StIssue: begin
                    if (last_q) begin
                        stage_q    <= stage_q + 2'd1;
                        stage_wrap <= (stage_q == 2'd3);
                    end
                    gap_cnt_q <= (gap_cnt_q == 3'd0) ? 3'd0 : gap_cnt_q - 3'd1;
                    state_q   <= (gap_cnt_q <= 3'd1) ? StIdle : StGap;
                end
                StGap: begin
                    gap_cnt_q <= (gap_cnt_q == 3'd0) ? 3'd0 : gap_cnt_q - 3'd1;
                    if (gap_cnt_q <= 3'd1) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // A retire coinciding with an issue cancels out.
            if (issue && !retire) begin
                credits <= credits - 3'd1;
            end else if (!issue && retire) begin
                if (credits == DepthC) begin
                    err_retire <= 1'b1;
                end else begin
                    credits <= credits + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mm_tag_issuer.sv
// Directed bench for mm_tag_issuer: reset, single issue, credit exhaustion, issue/retire
// overlap, spurious retire, stage wrap and reset in the middle of a gap.
module tb_mm_tag_issuer;

    localparam int unsigned INFO_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en_a;
    logic              en_c;
    logic [1:0]        stage_num_out;
    logic [INFO_W-1:0] mm_info_out;
    logic              en_out_a = 1'b0;
    logic              en_out_c = 1'b0;
    logic [2:0]        credits;
    logic              stage_wrap;
    logic              err_retire;

    int checks   = 0;
    int failures = 0;
    int wrap_seen = 0;

    always #5 clk = ~clk;

    mm_tag_issuer_if #(.INFO_W(INFO_W)) req_if ();

    mm_tag_issuer #(
        .DEPTH (4),
        .INFO_W(INFO_W),
        .GAP_A (4),
        .GAP_C (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req_if.slave),
        .en_a         (en_a),
        .en_c         (en_c),
        .stage_num_out(stage_num_out),
        .mm_info_out  (mm_info_out),
        .en_out_a     (en_out_a),
        .en_out_c     (en_out_c),
        .credits      (credits),
        .stage_wrap   (stage_wrap),
        .err_retire   (err_retire)
    );

    always @(negedge clk) if (stage_wrap === 1'b1) wrap_seen++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (req_if.req_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (req_if.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_timeout got=%b exp=1", name, req_if.req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks += 5;
        if (credits !== 3'd4) begin failures++; $display("FAIL rst_credits got=%0d exp=4", credits); end
        if ({en_a, en_c} !== 2'b00) begin failures++; $display("FAIL rst_strobes got=%b exp=00", {en_a, en_c}); end
        if (stage_num_out !== 2'd0 || mm_info_out !== 8'h00) begin
            failures++; $display("FAIL rst_tags got=%0d/%0h exp=0/0", stage_num_out, mm_info_out);
        end
        if ({stage_wrap, err_retire} !== 2'b00) begin
            failures++; $display("FAIL rst_flags got=%b exp=00", {stage_wrap, err_retire});
        end
        if (req_if.req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", req_if.req_ready); end
    endtask

    task automatic test_single_a();
        checks++;
        if (req_if.req_ready !== 1'b1) begin failures++; $display("FAIL a_ready_t got=%b exp=1", req_if.req_ready); end
        req_if.req_valid = 1'b1; req_if.req_type = 1'b0; req_if.req_info = 8'h5A; req_if.req_last = 1'b0;
        step();
        req_if.req_valid = 1'b0;
        checks += 3;
        if ({en_a, en_c} !== 2'b10) begin failures++; $display("FAIL a_strobe got=%b exp=10", {en_a, en_c}); end
        if (stage_num_out !== 2'd0 || mm_info_out !== 8'h5A) begin
            failures++; $display("FAIL a_tags got=%0d/%0h exp=0/5a", stage_num_out, mm_info_out);
        end
        if (req_if.req_ready !== 1'b0) begin failures++; $display("FAIL a_ready_t1 got=%b exp=0", req_if.req_ready); end
        step();
        checks += 2;
        if ({en_a, en_c} !== 2'b00) begin failures++; $display("FAIL a_strobe_t2 got=%b exp=00", {en_a, en_c}); end
        if (req_if.req_ready !== 1'b0) begin failures++; $display("FAIL a_ready_t2 got=%b exp=0", req_if.req_ready); end
        step();
        checks++;
        if (req_if.req_ready !== 1'b0) begin failures++; $display("FAIL a_ready_t3 got=%b exp=0", req_if.req_ready); end
        step();
        checks += 3;
        if (req_if.req_ready !== 1'b1) begin failures++; $display("FAIL a_ready_t4 got=%b exp=1", req_if.req_ready); end
        if (credits !== 3'd3) begin failures++; $display("FAIL a_credits got=%0d exp=3", credits); end
        if (mm_info_out !== 8'h5A) begin failures++; $display("FAIL a_info_hold got=%0h exp=5a", mm_info_out); end
        en_out_a = 1'b1;
        step();
        en_out_a = 1'b0;
        checks += 2;
        if (credits !== 3'd4) begin failures++; $display("FAIL a_refill got=%0d exp=4", credits); end
        if (err_retire !== 1'b0) begin failures++; $display("FAIL a_err got=%b exp=0", err_retire); end
    endtask

    task automatic test_credit_exhaustion();
        logic [15:0] mask = '0;
        req_if.req_valid = 1'b1; req_if.req_type = 1'b1; req_if.req_info = 8'hC0; req_if.req_last = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (en_c === 1'b1) mask[k] = 1'b1;
        end
        checks += 3;
        if (mask !== 16'h0492) begin failures++; $display("FAIL exh_strobe_cycles got=%h exp=0492", mask); end
        if (credits !== 3'd0) begin failures++; $display("FAIL exh_credits got=%0d exp=0", credits); end
        if (req_if.req_ready !== 1'b0) begin failures++; $display("FAIL exh_ready got=%b exp=0", req_if.req_ready); end
        req_if.req_valid = 1'b0;
        en_out_c = 1'b1;
        step();
        en_out_c = 1'b0;
        checks += 2;
        if (credits !== 3'd1) begin failures++; $display("FAIL exh_retire_credits got=%0d exp=1", credits); end
        if (req_if.req_ready !== 1'b1) begin failures++; $display("FAIL exh_retire_ready got=%b exp=1", req_if.req_ready); end
    endtask

    task automatic test_issue_retire_overlap();
        en_out_c = 1'b1;
        step();
        en_out_c = 1'b0;
        checks++;
        if (credits !== 3'd2) begin failures++; $display("FAIL ovl_pre_credits got=%0d exp=2", credits); end
        req_if.req_valid = 1'b1; req_if.req_type = 1'b0; req_if.req_info = 8'h33; req_if.req_last = 1'b0;
        step();
        req_if.req_valid = 1'b0;
        en_out_a = 1'b1;
        checks++;
        if (en_a !== 1'b1) begin failures++; $display("FAIL ovl_strobe got=%b exp=1", en_a); end
        step();
        en_out_a = 1'b0;
        checks++;
        if (credits !== 3'd2) begin failures++; $display("FAIL ovl_credits got=%0d exp=2", credits); end
        wait_ready("ovl");
        checks++;
        if (credits !== 3'd2) begin failures++; $display("FAIL ovl_idle_credits got=%0d exp=2", credits); end
    endtask

    task automatic test_spurious_retire();
        en_out_a = 1'b1;
        step();
        step();
        en_out_a = 1'b0;
        checks += 2;
        if (credits !== 3'd4) begin failures++; $display("FAIL sp_fill got=%0d exp=4", credits); end
        if (err_retire !== 1'b0) begin failures++; $display("FAIL sp_err_pre got=%b exp=0", err_retire); end
        en_out_c = 1'b1;
        step();
        en_out_c = 1'b0;
        checks += 2;
        if (credits !== 3'd4) begin failures++; $display("FAIL sp_credits got=%0d exp=4", credits); end
        if (err_retire !== 1'b1) begin failures++; $display("FAIL sp_err got=%b exp=1", err_retire); end
        repeat (3) step();
        checks++;
        if (err_retire !== 1'b1) begin failures++; $display("FAIL sp_err_sticky got=%b exp=1", err_retire); end
    endtask

    task automatic test_stage_wrap();
        logic [1:0] exp_stage [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        int base = wrap_seen;
        for (int j = 0; j < 5; j++) begin
            wait_ready("wrap");
            req_if.req_valid = 1'b1; req_if.req_type = 1'b0;
            req_if.req_info = 8'(8'h10 + j); req_if.req_last = 1'b1;
            step();
            req_if.req_valid = 1'b0;
            checks += 2;
            if (en_a !== 1'b1) begin failures++; $display("FAIL wrap_strobe%0d got=%b exp=1", j, en_a); end
            if (stage_num_out !== exp_stage[j]) begin
                failures++; $display("FAIL wrap_stage%0d got=%0d exp=%0d", j, stage_num_out, exp_stage[j]);
            end
            en_out_a = 1'b1;
            step();
            en_out_a = 1'b0;
            checks++;
            if (stage_wrap !== (j == 3)) begin
                failures++; $display("FAIL wrap_pulse%0d got=%b exp=%b", j, stage_wrap, (j == 3));
            end
        end
        repeat (3) step();
        checks += 2;
        if (wrap_seen - base != 1) begin failures++; $display("FAIL wrap_count got=%0d exp=1", wrap_seen - base); end
        if (credits !== 3'd4) begin failures++; $display("FAIL wrap_credits got=%0d exp=4", credits); end
    endtask

    task automatic test_reset_mid_gap();
        for (int j = 0; j < 3; j++) begin
            wait_ready("midgap");
            req_if.req_valid = 1'b1; req_if.req_type = 1'b1;
            req_if.req_info = 8'(8'hA0 + j); req_if.req_last = 1'b0;
            step();
            req_if.req_valid = 1'b0;
        end
        step();
        checks += 2;
        if (credits !== 3'd1) begin failures++; $display("FAIL mg_credits_pre got=%0d exp=1", credits); end
        if (req_if.req_ready !== 1'b0) begin failures++; $display("FAIL mg_ready_pre got=%b exp=0", req_if.req_ready); end
        rst = 1'b1; en_out_c = 1'b1; req_if.req_valid = 1'b1;
        step();
        step();
        rst = 1'b0; en_out_c = 1'b0; req_if.req_valid = 1'b0;
        checks += 5;
        if (credits !== 3'd4) begin failures++; $display("FAIL mg_credits got=%0d exp=4", credits); end
        if ({en_a, en_c} !== 2'b00) begin failures++; $display("FAIL mg_strobes got=%b exp=00", {en_a, en_c}); end
        if (stage_num_out !== 2'd0 || mm_info_out !== 8'h00) begin
            failures++; $display("FAIL mg_tags got=%0d/%0h exp=0/0", stage_num_out, mm_info_out);
        end
        if (err_retire !== 1'b0) begin failures++; $display("FAIL mg_err got=%b exp=0", err_retire); end
        if (req_if.req_ready !== 1'b1) begin failures++; $display("FAIL mg_ready got=%b exp=1", req_if.req_ready); end
        req_if.req_valid = 1'b1; req_if.req_type = 1'b0; req_if.req_info = 8'h77; req_if.req_last = 1'b0;
        step();
        req_if.req_valid = 1'b0;
        checks += 2;
        if (en_a !== 1'b1) begin failures++; $display("FAIL mg_post_strobe got=%b exp=1", en_a); end
        if (stage_num_out !== 2'd0) begin failures++; $display("FAIL mg_post_stage got=%0d exp=0", stage_num_out); end
        repeat (4) step();
    endtask

    initial begin
        req_if.req_valid = 1'b0;
        req_if.req_type  = 1'b0;
        req_if.req_info  = '0;
        req_if.req_last  = 1'b0;
        test_reset();
        test_single_a();
        test_credit_exhaustion();
        test_issue_retire_overlap();
        test_spurious_retire();
        test_stage_wrap();
        test_reset_mid_gap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
